fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Serial coefficient writer for the 5-tap FIR datapath. It receives a framed bit-serial stream of five 12-bit signed coefficients, assembles them in a shadow shift register, and commits all five to the parallel `c0`..`c4` buses in one clock edge, so the filter never sees a mixed coefficient set. It sits between the control or test interface and the coefficient inputs of the filter wrapper, and drives those inputs directly.

## Interface

Parameters:
- `W`, 12: coefficient width, two's complement.
- `NTAP`, 5: number of coefficients per frame. The frame length is `NTAP*W` = 60 bits.

Ports:
- `clk`  in  1: system clock. All state is updated on the rising edge.
- `rst`  in  1: one clock; reset is asynchronous and active-high.
- `s_frame`  in  1: frame enable. It stays high for exactly one load frame.
- `s_data`  in  1: serial coefficient bit, sampled on each edge where `s_frame`=1.
- `c0`..`c4`  out  W signed: active coefficients.
- `coef_valid`  out  1: high once at least one frame has been committed since reset.
- `load_done`  out  1: one-cycle pulse on a commit.
- `load_err`  out  1: one-cycle pulse when a frame is rejected.
- `busy`  out  1: high while a frame is being received (states SHIFT and OVER).

## Operation

- **Bit order:** `c0` is sent first and `c4` last. Each coefficient is sent MSB first. After 60 bits, shadow[59:48]=c0 and shadow[11:0]=c4.
- **State machine:** three states, IDLE, SHIFT and OVER. A 6-bit counter `cnt` tracks received bits.
  - **IDLE:**
    - `s_frame`=1: shift `s_data` into the shadow register, set `cnt`=1, go to SHIFT.
    - Otherwise: hold.
  - **SHIFT:**
    - `s_frame`=1 and `cnt`<60: shift in the bit, increment `cnt`.
    - `s_frame`=1 and `cnt`==60: this is the 61st bit. Do not shift; go to OVER.
    - `s_frame`=0 and `cnt`==60: commit. Load `c0`..`c4` from the shadow register, set `coef_valid`=1, pulse `load_done`, go to IDLE.
    - `s_frame`=0 and `cnt`<60: short frame. Pulse `load_err`, leave `c*` unchanged, go to IDLE.
  - **OVER:**
    - `s_frame`=1: discard bits.
    - `s_frame`=0: pulse `load_err`, leave `c*` unchanged, go to IDLE.
- **No partial updates:** `c*` change only on a commit edge. The shadow register is internal and is never visible on the outputs.
- **No arithmetic:** coefficients pass bit-exact, with no sign extension or saturation. `c*` are declared `signed`.
- **Frame spacing:** back-to-back frames need one cycle of `s_frame`=0 between them; that cycle is the commit/err cycle. A frame may start on the cycle immediately after it. A 1-cycle gap is legal.
- **Reset** (any time, including mid-frame or in OVER):
  - State goes to IDLE and `cnt`=0.
  - The shadow register is cleared.
  - `c0`..`c4` go to 0.
  - `coef_valid`, `load_done`, `load_err` and `busy` go to 0.
  - Reset forces all of this immediately, without waiting for a clock edge.
- A rejected frame does not clear `coef_valid`.

## Timing

- All outputs are registered, with no combinational paths from inputs to outputs.
- **Frame timing:** bit k is sampled at edge E0+k, for k = 0..59. `s_frame` is sampled low at edge E60.
- **At edge E60:**
  - `c*` take their new values.
  - `load_done`=1 for the cycle after E60, then returns to 0 at E61.
- Latency from the last data bit to the new coefficients is 1 clock.
- **`load_err` timing:** it is asserted for exactly one cycle, after the edge that samples `s_frame`=0 in SHIFT (short frame) or in OVER.
- **`busy` timing:** it goes to 1 after E0 and to 0 after the closing edge.
- **Pulse exclusivity:** `load_done` and `load_err` are never both high. Neither is high for two consecutive cycles unless two frames close on consecutive closing edges.

## Test plan

1. **Reset values:** assert `rst` with no clock edges -> all outputs are 0 immediately. Deassert, then idle 10 cycles -> outputs still 0.
2. **Nominal load:** send `c0`=12'h001, `c1`=12'hFFE, `c2`=12'h7FF, `c3`=12'h800, `c4`=12'h123 (60 bits, then 1 low cycle) ->
   - `c*` match exactly, with `c1` read as -2 and `c3` as -2048.
   - `load_done` is high for 1 cycle, exactly 61 edges after the first bit.
   - `coef_valid`=1.
3. **Short frame:** after scenario 2, send a 59-bit frame -> one `load_err` pulse. `c*` still hold the scenario 2 values and `coef_valid` stays 1.
4. **Long frame:** send a 64-bit frame -> `busy` stays high until `s_frame` falls. Then one `load_err` pulse, `c*` unchanged, no `load_done`.
5. **Back-to-back frames:** send frame A (all coefficients 12'hAAA) and frame B (12'h555) separated by a 1-cycle gap -> two `load_done` pulses. `c*` hold 12'hAAA for exactly 61 cycles, then 12'h555.
6. **Reset mid-frame:** assert `rst` after bit 30 of a frame, deassert, then send a full frame with all coefficients 12'h0F0 ->
   - `c*` are 0 during reset.
   - After the full frame, `c*` are 12'h0F0.
   - No `load_err` pulse from the aborted frame.

Source files
------------

// File: rtl/fir_coef_loader.sv
// Bit-serial loader for the FIR coefficient bank: shifts a 60-bit frame into a shadow register and commits all taps on one edge.
// Latency: commit 1 clk after the last data bit; no backpressure, the serial stream is accepted every cycle s_frame is high.
module fir_coef_loader #(
  parameter int W    = 12,
  parameter int NTAP = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_frame,
  input  logic                s_data,
  output logic signed [W-1:0] c0,
  output logic signed [W-1:0] c1,
  output logic signed [W-1:0] c2,
  output logic signed [W-1:0] c3,
  output logic signed [W-1:0] c4,
  output logic                coef_valid,
  output logic                load_done,
  output logic                load_err,
  output logic                busy
);

  localparam int         FLEN   = NTAP * W;
  localparam logic [5:0] FLEN_C = 6'(FLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  state_t            state, state_nxt;
  logic [5:0]        cnt, cnt_nxt;
  logic [FLEN-1:0]   shadow, shadow_nxt;
  logic              commit, reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    commit     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (s_frame) begin
          shadow_nxt = {shadow[FLEN-2:0], s_data};
          cnt_nxt    = 6'd1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (s_frame) begin
          // A 61st bit marks the frame as overlong; stop shifting and wait for it to end.
          if (cnt == FLEN_C) begin
            state_nxt = OVER;
          end else begin
            shadow_nxt = {shadow[FLEN-2:0], s_data};
            cnt_nxt    = cnt + 6'd1;
          end
        end else begin
          commit    = (cnt == FLEN_C);
          reject    = (cnt != FLEN_C);
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      OVER: begin
        if (!s_frame) begin
          reject    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are all registered; the coefficient bank only moves on a commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0         <= '0;
      c1         <= '0;
      c2         <= '0;
      c3         <= '0;
      c4         <= '0;
      coef_valid <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_done <= commit;
      load_err  <= reject;
      busy      <= (state_nxt != IDLE);
      if (commit) begin
        c0         <= shadow[4*W +: W];
        c1         <= shadow[3*W +: W];
        c2         <= shadow[2*W +: W];
        c3         <= shadow[1*W +: W];
        c4         <= shadow[0*W +: W];
        coef_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: frames are driven serially, expected coefficient sets queue up and are matched on load_done.
module tb_fir_coef_loader;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_frame;
  logic               s_data;
  logic signed [11:0] c0, c1, c2, c3, c4;
  logic               coef_valid, load_done, load_err, busy;

  fir_coef_loader #(.W(12), .NTAP(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_frame   (s_frame),
    .s_data    (s_data),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .c4        (c4),
    .coef_valid(coef_valid),
    .load_done (load_done),
    .load_err  (load_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int t0         = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int aaa_cycles = 0;
  int busy_lo    = 0;
  logic [59:0] exp_q[$];

  localparam logic [59:0] F2   = {12'h001, 12'hFFE, 12'h7FF, 12'h800, 12'h123};
  localparam logic [59:0] FA   = {5{12'hAAA}};
  localparam logic [59:0] FB   = {5{12'h555}};
  localparam logic [59:0] F0F0 = {5{12'h0F0}};

  task automatic chk60(input string tag, input logic [59:0] obs, input logic [59:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] coefs();
    return {c0, c1, c2, c3, c4};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every commit must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (load_done) begin
        done_cnt++;
        chk_int("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk60("commit_coefs", coefs(), exp_q.pop_front());
          chk1("commit_valid", coef_valid, 1'b1);
        end
      end
      if (load_err) err_cnt++;
      if (load_done || load_err) chk1("pulse_excl", load_done & load_err, 1'b0);
      if (coefs() == FA) aaa_cycles++;
    end
  end

  // Bit k of the frame is bits[63-k]; busy must be high at every negedge after the first bit.
  task automatic shift_bits(input logic [63:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k >= 1 && !busy) busy_lo++;
      if (k == 0) t0 = cyc + 1;
      s_frame = 1'b1;
      s_data  = bits[63-k];
    end
  endtask

  task automatic close_frame();
    @(negedge clk);
    if (!busy) busy_lo++;
    s_frame = 1'b0;
    s_data  = 1'b0;
  endtask

  task automatic send_good(input logic [59:0] f);
    exp_q.push_back(f);
    shift_bits({f, 4'h0}, 60);
    close_frame();
  endtask

  task automatic chk_all_zero(input string tag);
    chk60({tag, "_coefs"}, coefs(), 60'h0);
    chk1({tag, "_valid"}, coef_valid, 1'b0);
    chk1({tag, "_done"}, load_done, 1'b0);
    chk1({tag, "_err"}, load_err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int e0, d0;
    // Reset values, before any clock edge.
    rst     = 1'b1;
    s_frame = 1'b0;
    s_data  = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_all_zero("rst_idle");

    // Nominal load, with latency and signed readback.
    send_good(F2);
    @(negedge clk);
    chk1("nom_done", load_done, 1'b1);
    chk_int("nom_latency_edges", cyc - t0 + 1, 61);
    chk_int("nom_c1_signed", int'(c1), -2);
    chk_int("nom_c3_signed", int'(c3), -2048);
    chk1("nom_valid", coef_valid, 1'b1);
    chk1("nom_busy_after", busy, 1'b0);
    @(negedge clk);
    chk1("nom_done_pulse", load_done, 1'b0);

    // Short frame: 59 bits.
    e0 = err_cnt;
    d0 = done_cnt;
    shift_bits({FB, 4'h0}, 59);
    close_frame();
    @(negedge clk);
    chk1("short_err", load_err, 1'b1);
    @(negedge clk);
    chk1("short_err_pulse", load_err, 1'b0);
    chk_int("short_err_cnt", err_cnt - e0, 1);
    chk_int("short_no_done", done_cnt - d0, 0);
    chk60("short_coefs_hold", coefs(), F2);
    chk1("short_valid_hold", coef_valid, 1'b1);

    // Long frame: 64 bits.
    e0 = err_cnt;
    d0 = done_cnt;
    busy_lo = 0;
    shift_bits(64'hDEAD_BEEF_0123_4567, 64);
    close_frame();
    chk_int("long_busy_held", busy_lo, 0);
    @(negedge clk);
    chk1("long_err", load_err, 1'b1);
    chk1("long_busy_clr", busy, 1'b0);
    @(negedge clk);
    chk_int("long_err_cnt", err_cnt - e0, 1);
    chk_int("long_no_done", done_cnt - d0, 0);
    chk60("long_coefs_hold", coefs(), F2);

    // Back-to-back frames with a single-cycle gap.
    d0 = done_cnt;
    e0 = err_cnt;
    aaa_cycles = 0;
    send_good(FA);
    send_good(FB);
    repeat (3) @(negedge clk);
    chk_int("b2b_done_cnt", done_cnt - d0, 2);
    chk_int("b2b_aaa_cycles", aaa_cycles, 61);
    chk60("b2b_coefs_final", coefs(), FB);
    chk_int("b2b_no_err", err_cnt - e0, 0);

    // Reset in the middle of a frame.
    e0 = err_cnt;
    shift_bits(64'h1234_5678_9ABC_DEF0, 30);
    @(negedge clk);
    s_frame = 1'b0;
    rst     = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_good(F0F0);
    repeat (2) @(negedge clk);
    chk60("midrst_reload", coefs(), F0F0);
    chk1("midrst_valid", coef_valid, 1'b1);
    chk_int("midrst_no_err", err_cnt - e0, 0);

    repeat (3) @(negedge clk);
    chk_int("sb_drained", exp_q.size(), 0);
    chk_int("total_done", done_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
